// File: rtl/ram_dp_be.sv
// ram_dp_be -- simple dual-port synchronous RAM with per-byte write enables.
//
// One write port and one read port share a single clock. The read port has a
// latency of one cycle, or two when OUT_REG=1, and accepts one read per cycle.
// RDW_MODE chooses what a read returns when it hits the word being written on
// the same edge: 0 returns the old word, 1 returns the merged word. With
// CLEAR_ON_RST=1, every reset starts a sweep that zeroes the whole array. The
// sweep takes 2**ADDR_WIDTH cycles and all requests are ignored while it runs.
//
// Ports
//   clk       clock, all logic on posedge
//   rst_n     synchronous active-low reset
//   wr_en     write request
//   wr_addr   write address
//   wr_data   write data
//   wr_be     byte enables, bit i covers wr_data[8i+7:8i]
//   rd_en     read request
//   rd_addr   read address
//   rd_data   read data, holds its last value while rd_valid=0
//   rd_valid  one-cycle pulse per accepted read
//   busy      high while the clear sweep runs

module ram_dp_be #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter     INIT_FILE    = "",
    parameter int RDW_MODE     = 0,
    parameter int OUT_REG      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    busy
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    valid_s1;
    logic [DATA_WIDTH-1:0]   data_s1;
    logic                    valid_s2;
    logic [DATA_WIDTH-1:0]   data_s2;

    logic                    accept_wr;
    logic                    accept_rd;

    // Requests are only honoured once the sweep is over and reset is released.
    assign accept_wr = rst_n && (state == READY) && wr_en;
    assign accept_rd = rst_n && (state == READY) && rd_en;

    // NOTE: the array has no reset branch, so it maps onto block RAM. It is
    // cleared by the sweep one word per cycle, and it is not written at all
    // while rst_n is low.
    always_ff @(posedge clk) begin
        if (rst_n && (state == CLEAR)) begin
            mem[clr_addr] <= '0;
        end else if (accept_wr) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // In RDW_MODE=1, a read that hits the word being written returns the
    // enabled bytes of wr_data and the stored value of the other bytes.
    // NOTE: rd_word gets a default before any conditional update, so this
    // block cannot infer a latch.
    always_comb begin
        rd_word = mem[rd_addr];
        if ((RDW_MODE != 0) && accept_wr && (wr_addr == rd_addr)) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments, so each
    // register samples the values that held before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
            clr_addr <= '0;
            valid_s1 <= 1'b0;
            data_s1  <= '0;
            valid_s2 <= 1'b0;
            data_s2  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == {ADDR_WIDTH{1'b1}}) begin
                        state <= READY;
                    end
                end
                default: state <= READY;
            endcase

            // Data registers load only on an accepted read, so rd_data keeps
            // its value between reads.
            valid_s1 <= accept_rd;
            if (accept_rd) begin
                data_s1 <= rd_word;
            end

            valid_s2 <= valid_s1;
            if (valid_s1) begin
                data_s2 <= data_s1;
            end
        end
    end

    assign rd_valid = (OUT_REG != 0) ? valid_s2 : valid_s1;
    assign rd_data  = (OUT_REG != 0) ? data_s2  : data_s1;
    assign busy     = (state == CLEAR);

endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be -- self-checking bench for ram_dp_be.
//
// Two instances share the same stimulus: dut0 uses RDW_MODE=0 and OUT_REG=0,
// and dut1 uses RDW_MODE=1 and OUT_REG=1. Each read pushes an expected word
// and its issue cycle into that instance's queue. A monitor per instance pops
// one entry on every rd_valid pulse and checks the data and the latency.

module tb_ram_dp_be;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int BW = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [BW-1:0] wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;
    logic          busy0, busy1;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc;
    int   checks;
    int   errors;

    ram_dp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0)
    );

    ram_dp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitors sample on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid0) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected rd_valid", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                check("dut0 rd_data", 32'(rd_data0), 32'(e.data));
                check("dut0 latency", 32'(cyc - e.cyc), 32'd1);
            end
        end
        if (rd_valid1) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected rd_valid", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("dut1 rd_data", 32'(rd_data1), 32'(e.data));
                check("dut1 latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        rd_en = 1'b1; rd_addr = a;
        q0.push_back('{data: e0, cyc: cyc});
        q1.push_back('{data: e1, cyc: cyc});
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_wr_rd(input logic [AW-1:0] wa, input logic [DW-1:0] d, input logic [BW-1:0] be,
                            input logic [AW-1:0] ra, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        wr_en = 1'b1; wr_addr = wa; wr_data = d; wr_be = be;
        rd_en = 1'b1; rd_addr = ra;
        q0.push_back('{data: e0, cyc: cyc});
        q1.push_back('{data: e1, cyc: cyc});
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // Measures how many cycles busy stays high after release. When the
    // argument is set, a write of 0xFFFF to address 2 and a read of address 2
    // are held on the ports for the whole sweep.
    task automatic release_and_sweep(input bit poke);
        int n;
        if (poke) begin
            wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF; wr_be = 2'b11;
            rd_en = 1'b1; rd_addr = 4'd2;
        end
        rst_n = 1'b1;
        n = 0;
        while (busy0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("busy cycles after release", 32'(n), 32'd16);
        check("busy low after sweep", 32'(busy1), 32'd0);
    endtask

    task automatic hold_reset(input bit poke);
        rst_n = 1'b0;
        if (poke) begin
            wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF; wr_be = 2'b11;
            rd_en = 1'b1; rd_addr = 4'd2;
        end
        repeat (2) @(negedge clk);
        check("reset rd_valid", {30'd0, rd_valid1, rd_valid0}, 32'd0);
        check("reset rd_data dut0", 32'(rd_data0), 32'd0);
        check("reset rd_data dut1", 32'(rd_data1), 32'd0);
        check("reset busy", {30'd0, busy1, busy0}, 32'd3);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
        @(negedge clk);

        // Reset, then a 16-cycle sweep, then every word reads back as zero.
        hold_reset(1'b0);
        release_and_sweep(1'b0);
        for (int i = 0; i < 16; i++) do_read(4'(i), 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);

        // Byte enables: a full write, then a low-byte write, then wr_be=0,
        // which must change nothing.
        do_write(4'd3, 16'hBEEF, 2'b11);
        do_write(4'd3, 16'h1234, 2'b01);
        do_write(4'd3, 16'hFFFF, 2'b00);
        do_read(4'd3, 16'hBE34, 16'hBE34);
        repeat (4) @(negedge clk);
        check("rd_data hold dut0", 32'(rd_data0), 32'h0000BE34);
        check("rd_data hold dut1", 32'(rd_data1), 32'h0000BE34);
        check("rd_valid idle", {30'd0, rd_valid1, rd_valid0}, 32'd0);

        // Read and write of the same address on the same edge.
        do_write(4'd5, 16'h5555, 2'b11);
        do_wr_rd(4'd5, 16'hAAAA, 2'b11, 4'd5, 16'h5555, 16'hAAAA);
        do_write(4'd5, 16'h5555, 2'b11);
        do_wr_rd(4'd5, 16'hAAAA, 2'b10, 4'd5, 16'h5555, 16'hAA55);
        do_read(4'd5, 16'hAA55, 16'hAA55);
        // Read and write of different addresses on the same edge.
        do_wr_rd(4'd6, 16'hA5A5, 2'b11, 4'd5, 16'hAA55, 16'hAA55);
        do_read(4'd6, 16'hA5A5, 16'hA5A5);
        repeat (3) @(negedge clk);

        // Requests during the sweep are ignored, and the sweep clears mem[2].
        do_write(4'd2, 16'hFFFF, 2'b11);
        hold_reset(1'b1);
        release_and_sweep(1'b1);
        do_read(4'd2, 16'h0000, 16'h0000);
        do_read(4'd3, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);

        // A reset at sweep cycle 7 restarts the full sweep.
        hold_reset(1'b0);
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        hold_reset(1'b0);
        release_and_sweep(1'b0);

        // Reset with a read in flight. dut0 delivers its read on the next
        // edge. dut1's read is still in the pipeline when reset hits, so it
        // must never pulse. The read held during reset is also dropped.
        do_write(4'd3, 16'h1111, 2'b11);
        rd_en = 1'b1; rd_addr = 4'd3;
        q0.push_back('{data: 16'h1111, cyc: cyc});
        @(negedge clk);
        hold_reset(1'b0);
        rd_en = 1'b0;
        release_and_sweep(1'b0);

        // Write mem[i]=i, then read back-to-back at one word per cycle.
        for (int i = 0; i < 16; i++) do_write(4'(i), 16'(i), 2'b11);
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_addr = 4'(i);
            q0.push_back('{data: 16'(i), cyc: cyc});
            q1.push_back('{data: 16'(i), cyc: cyc});
            @(negedge clk);
        end
        rd_en = 1'b0;
        repeat (5) @(negedge clk);

        check("dut0 reads outstanding", 32'(q0.size()), 32'd0);
        check("dut1 reads outstanding", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
